// File: rtl/isa_io_cycle_master.sv
// ---------------------------------------------------------------------------
// isa_io_cycle_master
//
// Avalon-MM slave that turns each single-word HPS read or write into one
// timed 16-bit ISA I/O cycle on the riser bus. A cycle runs through these
// phases:
//   SETUP : address (and write data) valid, command still high
//   CMD   : IOR#/IOW# low for a minimum time, then stretched while the
//           synchronised IOCHRDY is low (bounded by a timeout)
//   HOLD  : command released, address/write data still held
//   DONE  : waitrequest low for one clock, completing the Avalon transfer
//
// Ports
//   clk              system clock (50 MHz nominal)
//   reset_n          asynchronous active-low reset
//   avs_address      ISA I/O port address
//   avs_read         Avalon read request
//   avs_write        Avalon write request (wins if both are asserted)
//   avs_writedata    write data
//   avs_readdata     read data, valid while avs_waitrequest is low
//   avs_waitrequest  Avalon stall, low only in DONE
//   isa_addr         ISA address bus (holds the last address when idle)
//   isa_data         ISA data bus, driven only during a write cycle
//   isa_ior_n        I/O read command, active low
//   isa_iow_n        I/O write command, active low
//   isa_iochrdy      ISA ready (asynchronous), low extends the command
//   err_timeout      one-clock pulse when a cycle ended by timeout
// ---------------------------------------------------------------------------
module isa_io_cycle_master #(
    parameter int SETUP_CYC   = 4,
    parameter int CMD_CYC     = 27,
    parameter int HOLD_CYC    = 2,
    parameter int RDY_TIMEOUT = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [15:0] isa_addr,
    inout  wire  [15:0] isa_data,
    output logic        isa_ior_n,
    output logic        isa_iow_n,
    input  logic        isa_iochrdy,
    output logic        err_timeout
);

    // One counter width covers every phase length and the extension limit,
    // so none of the counters can wrap.
    localparam int MAX_SC  = (SETUP_CYC > CMD_CYC) ? SETUP_CYC : CMD_CYC;
    localparam int MAX_SCH = (MAX_SC > HOLD_CYC) ? MAX_SC : HOLD_CYC;
    localparam int CNT_MAX = (MAX_SCH > RDY_TIMEOUT) ? MAX_SCH : RDY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT  = CNT_W'(RDY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  ext_cnt;
    logic              is_wr;
    logic              data_oe;
    logic [15:0]       data_lat;
    logic              rdy_meta;
    logic              rdy_s;

    logic              min_done;
    logic              cmd_tmo;
    logic              cmd_end;
    logic              accept;

    // Saturating increment: a counter parked at all-ones stays there rather
    // than wrapping back into a value that could re-trigger a phase exit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    assign accept   = (state == S_IDLE) && (avs_write || avs_read);
    assign min_done = (phase_cnt == CMD_LAST);
    // Ready is checked before the timeout, so a device that releases
    // IOCHRDY on the very last allowed cycle still completes normally.
    assign cmd_tmo  = min_done && !rdy_s && (ext_cnt == TMO_LIMIT);
    assign cmd_end  = min_done && (rdy_s || (ext_cnt == TMO_LIMIT));

    // Write data drives the bus from SETUP through HOLD; the enable is a
    // reset-cleared flop so an asynchronous reset floats the bus at once.
    assign isa_data = data_oe ? data_lat : 16'bz;

    // IOCHRDY is asynchronous to clk: two-flop synchroniser. Resets to
    // "ready" so a fresh cycle never starts from a stale extend request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_meta <= 1'b1;
            rdy_s    <= 1'b1;
        end else begin
            rdy_meta <= isa_iochrdy;
            rdy_s    <= rdy_meta;
        end
    end

    // Write data latch: pure data path, captured on acceptance only.
    always_ff @(posedge clk) begin
        if (accept)
            data_lat <= avs_writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            phase_cnt       <= '0;
            ext_cnt         <= '0;
            is_wr           <= 1'b0;
            data_oe         <= 1'b0;
            isa_addr        <= 16'h0000;
            avs_readdata    <= 16'h0000;
            avs_waitrequest <= 1'b1;
            isa_ior_n       <= 1'b1;
            isa_iow_n       <= 1'b1;
            err_timeout     <= 1'b0;
        end else begin
            avs_waitrequest <= 1'b1;
            err_timeout     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        isa_addr  <= avs_address;
                        is_wr     <= avs_write;
                        data_oe   <= avs_write;
                        phase_cnt <= '0;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        phase_cnt <= '0;
                        ext_cnt   <= '0;
                        isa_ior_n <= is_wr;
                        isa_iow_n <= !is_wr;
                        state     <= S_CMD;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end

                S_CMD: begin
                    if (!min_done) begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end else if (cmd_end) begin
                        // Last command cycle: sample the bus while the
                        // command is still low, then release it.
                        if (cmd_tmo)
                            avs_readdata <= 16'hFFFF;
                        else if (!is_wr)
                            avs_readdata <= isa_data;
                        err_timeout <= cmd_tmo;
                        isa_ior_n   <= 1'b1;
                        isa_iow_n   <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= S_HOLD;
                    end else begin
                        ext_cnt <= sat_inc(ext_cnt);
                    end
                end

                S_HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        data_oe         <= 1'b0;
                        avs_waitrequest <= 1'b0;
                        phase_cnt       <= '0;
                        state           <= S_DONE;
                    end else begin
                        phase_cnt <= sat_inc(phase_cnt);
                    end
                end

                // Requests are deliberately not sampled here: the master is
                // still holding the completed request during this clock.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isa_io_cycle_master.sv
// ---------------------------------------------------------------------------
// tb_isa_io_cycle_master
//
// Directed and randomised ISA I/O cycles. For each transfer the expected
// timeline (command window, completion cycle, timeout) is worked out up
// front from the cycle rules, then every clock of the transfer is compared.
// Cycle 0 is the clock in which the request is first presented.
// ---------------------------------------------------------------------------
module tb_isa_io_cycle_master;

    localparam int SETUP_CYC   = 4;
    localparam int CMD_CYC     = 27;
    localparam int HOLD_CYC    = 2;
    localparam int RDY_TIMEOUT = 512;
    localparam int FOREVER_LO  = 100000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    wire  [15:0] avs_readdata;
    wire         avs_waitrequest;
    wire  [15:0] isa_addr;
    wire  [15:0] isa_data;
    wire         isa_ior_n;
    wire         isa_iow_n;
    logic        isa_iochrdy;
    wire         err_timeout;

    logic        tb_oe;
    logic [15:0] tb_dq;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_addr;

    assign isa_data = tb_oe ? tb_dq : 16'bz;

    always #10 clk = ~clk;

    isa_io_cycle_master #(
        .SETUP_CYC   (SETUP_CYC),
        .CMD_CYC     (CMD_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .RDY_TIMEOUT (RDY_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .isa_addr        (isa_addr),
        .isa_data        (isa_data),
        .isa_ior_n       (isa_ior_n),
        .isa_iow_n       (isa_iow_n),
        .isa_iochrdy     (isa_iochrdy),
        .err_timeout     (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // IOCHRDY level the bench applies in cycle c: low inside [lo_start, lo_start+lo_len).
    function automatic bit rdy_in(input int c, input int lo_start, input int lo_len);
        if (c < 0)
            return 1'b1;
        return !((c >= lo_start) && (c < lo_start + lo_len));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            avs_write   = 1'b0;
            avs_read    = 1'b0;
            isa_iochrdy = 1'b1;
            tb_oe       = 1'b1;
            tb_dq       = 16'h5A5A;
            @(negedge clk);
            chk("idle_wait", avs_waitrequest, 1'b1);
            chk("idle_bus", isa_data, 16'h5A5A);
        end
    endtask

    task automatic run_txn(input bit wr, input bit rd, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int lo_start, input int lo_len, input int rst_at);
        bit          is_wr;
        bit          tmo;
        int          cmd_first;
        int          min_last;
        int          cmd_last;
        int          done;
        logic [15:0] probe;
        logic [15:0] exp_bus;

        is_wr     = wr;
        tmo       = 1'b0;
        probe     = ~wdata;
        cmd_first = 1 + SETUP_CYC;
        min_last  = cmd_first + CMD_CYC - 1;
        cmd_last  = min_last;
        // The ready seen by the DUT in cycle c is the pin level of cycle c-2.
        for (int k = 0; k <= RDY_TIMEOUT; k++) begin
            cmd_last = min_last + k;
            if (rdy_in(cmd_last - 2, lo_start, lo_len))
                break;
            if (k == RDY_TIMEOUT)
                tmo = 1'b1;
        end
        done = cmd_last + HOLD_CYC + 1;

        for (int c = 0; c <= done + 1; c++) begin
            @(posedge clk); #1;
            avs_address   = addr;
            avs_writedata = wdata;
            avs_write     = (c <= done) ? wr : 1'b0;
            avs_read      = (c <= done) ? rd : 1'b0;
            isa_iochrdy   = (c <= done) ? rdy_in(c, lo_start, lo_len) : 1'b1;
            if (is_wr) begin
                tb_oe   = (c == 0) || (c >= done);
                tb_dq   = probe;
                exp_bus = tb_oe ? probe : wdata;
            end else begin
                tb_oe   = 1'b1;
                tb_dq   = ((c >= cmd_last - 3) && (c <= cmd_last)) ? rdata : ~rdata;
                exp_bus = tb_dq;
            end

            if (c == rst_at) begin
                reset_n = 1'b0;
                tb_oe   = 1'b1;
                tb_dq   = probe;
                #1;
                chk("rst_iow", isa_iow_n, 1'b1);
                chk("rst_ior", isa_ior_n, 1'b1);
                chk("rst_wait", avs_waitrequest, 1'b1);
                chk("rst_bus", isa_data, probe);
                chk("rst_addr", isa_addr, 16'h0000);
                @(negedge clk);
                avs_write   = 1'b0;
                avs_read    = 1'b0;
                isa_iochrdy = 1'b1;
                reset_n     = 1'b1;
                last_addr   = 16'h0000;
                return;
            end

            @(negedge clk);
            chk("addr", isa_addr, (c == 0) ? last_addr : addr);
            chk("ior_n", isa_ior_n, !(!is_wr && c >= cmd_first && c <= cmd_last));
            chk("iow_n", isa_iow_n, !(is_wr && c >= cmd_first && c <= cmd_last));
            chk("waitreq", avs_waitrequest, c != done);
            chk("err_timeout", err_timeout, tmo && (c == cmd_last + 1));
            chk("bus", isa_data, exp_bus);
            if ((c == done) && (!is_wr || tmo))
                chk("readdata", avs_readdata, tmo ? 16'hFFFF : rdata);
        end
        last_addr = addr;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] r;
        bit          w;
        bit          both;

        reset_n       = 1'b0;
        avs_address   = 16'h0000;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 16'h0000;
        isa_iochrdy   = 1'b1;
        tb_oe         = 1'b1;
        tb_dq         = 16'h0F0F;
        last_addr     = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_addr", isa_addr, 16'h0000);
        chk("reset_readdata", avs_readdata, 16'h0000);
        chk("reset_err", err_timeout, 1'b0);
        chk("reset_ior", isa_ior_n, 1'b1);
        chk("reset_iow", isa_iow_n, 1'b1);
        chk("reset_wait", avs_waitrequest, 1'b1);
        chk("reset_bus", isa_data, 16'h0F0F);
        reset_n = 1'b1;
        idle(2);

        // Nominal write and read
        run_txn(1'b1, 1'b0, 16'h0220, 16'h1234, 16'h0000, 0, 0, -1);
        idle(2);
        run_txn(1'b0, 1'b1, 16'h0388, 16'h7777, 16'hBEEF, 0, 0, -1);
        idle(2);

        // Read stretched by 40 low IOCHRDY cycles from cycle 10
        r = 16'($urandom);
        run_txn(1'b0, 1'b1, 16'h0300, 16'h0000, r, 10, 40, -1);
        idle(2);

        // Permanent IOCHRDY low: write then read both time out
        d = 16'($urandom);
        run_txn(1'b1, 1'b0, 16'h0310, d, 16'h0000, 0, FOREVER_LO, -1);
        idle(2);
        run_txn(1'b0, 1'b1, 16'h0310, 16'h0000, 16'h1357, 0, FOREVER_LO, -1);
        idle(2);

        // Read and write together: write wins
        run_txn(1'b1, 1'b1, 16'h0278, 16'hA55A, 16'h0000, 0, 0, -1);
        idle(1);

        // Randomised transfers with random ready windows
        for (int i = 0; i < 8; i++) begin
            a    = 16'($urandom);
            d    = 16'($urandom);
            r    = 16'($urandom);
            w    = 1'($urandom_range(0, 1));
            both = ($urandom_range(0, 3) == 0);
            run_txn(w, !w || both, a, d, r, $urandom_range(0, 45), $urandom_range(0, 40), -1);
            idle($urandom_range(1, 3));
        end

        // Reset during a write, then a normal read
        run_txn(1'b1, 1'b0, 16'h02F8, 16'hC0DE, 16'h0000, 0, 0, 15);
        idle(2);
        run_txn(1'b0, 1'b1, 16'h02E8, 16'h0000, 16'h4321, 0, 0, -1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
